// File: rtl/axis_video_checker.sv
// AXI4-Stream RGB video sink that checks frame geometry (tuser/tlast/line count)
// and the packed 18-bit incrementing payload, with sticky debug status.
module axis_video_checker #(
    parameter int H_PIX    = 640,
    parameter int V_LINES  = 480,
    parameter bit CHK_DATA = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        clr_err,
    input  logic [23:0] s_axis_video_tdata,
    input  logic        s_axis_video_tvalid,
    output logic        s_axis_video_tready,
    input  logic        s_axis_video_tuser,
    input  logic        s_axis_video_tlast,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        err_sof,
    output logic        err_eol,
    output logic        err_data,
    output logic [11:0] last_line_len
);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_e;

    localparam logic [11:0] X_LAST = 12'(H_PIX - 1);
    localparam logic [11:0] Y_LAST = 12'(V_LINES - 1);
    localparam logic [11:0] X_MAX  = 12'hFFF;

    state_e      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [17:0] exp_q, exp_d;
    logic        tready_q, tready_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_sof_q, err_sof_d;
    logic        err_eol_q, err_eol_d;
    logic        err_data_q, err_data_d;
    logic [11:0] last_len_q, last_len_d;

    logic        beat;
    logic [17:0] pix_val;
    logic        pad_bad;
    logic [11:0] x_cur, y_cur;

    assign beat    = s_axis_video_tvalid & tready_q;
    assign pix_val = {s_axis_video_tdata[23:18], s_axis_video_tdata[15:10], s_axis_video_tdata[7:2]};
    assign pad_bad = |{s_axis_video_tdata[17:16], s_axis_video_tdata[9:8], s_axis_video_tdata[1:0]};

    // NOTE: every variable gets its default before any branch, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        exp_d        = exp_q;
        tready_d     = enable;
        frame_done_d = 1'b0;
        frame_cnt_d  = clr_err ? 16'd0 : frame_cnt_q;
        err_sof_d    = clr_err ? 1'b0 : err_sof_q;
        err_eol_d    = clr_err ? 1'b0 : err_eol_q;
        err_data_d   = clr_err ? 1'b0 : err_data_q;
        last_len_d   = clr_err ? 12'd0 : last_len_q;
        x_cur        = x_q;
        y_cur        = y_q;

        // A tuser beat is pixel (0,0) whatever state we are in; error events below
        // are applied after the clear so that a simultaneous set wins.
        if (beat && (state_q == ACTIVE || s_axis_video_tuser)) begin
            if (state_q == ACTIVE) begin
                if (CHK_DATA && ((pix_val != exp_q) || pad_bad)) begin
                    err_data_d = 1'b1;
                end
                if (s_axis_video_tuser) begin
                    err_sof_d = 1'b1;
                end
            end
            if (s_axis_video_tuser) begin
                x_cur = 12'd0;
                y_cur = 12'd0;
            end
            exp_d   = pix_val + 18'd1;
            state_d = ACTIVE;

            if (s_axis_video_tlast) begin
                last_len_d = x_cur + 12'd1;
                if (x_cur != X_LAST) begin
                    err_eol_d = 1'b1;
                end
                x_d = 12'd0;
                if (y_cur == Y_LAST) begin
                    state_d      = WAIT_SOF;
                    y_d          = 12'd0;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_d + 16'd1;
                end else begin
                    y_d = y_cur + 12'd1;
                end
            end else begin
                if (x_cur == X_LAST) begin
                    err_eol_d = 1'b1;
                end
                x_d = (x_cur == X_MAX) ? X_MAX : x_cur + 12'd1;
                y_d = y_cur;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= WAIT_SOF;
            x_q          <= 12'd0;
            y_q          <= 12'd0;
            exp_q        <= 18'd0;
            tready_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
            err_sof_q    <= 1'b0;
            err_eol_q    <= 1'b0;
            err_data_q   <= 1'b0;
            last_len_q   <= 12'd0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            exp_q        <= exp_d;
            tready_q     <= tready_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_sof_q    <= err_sof_d;
            err_eol_q    <= err_eol_d;
            err_data_q   <= err_data_d;
            last_len_q   <= last_len_d;
        end
    end

    assign s_axis_video_tready = tready_q;
    assign frame_done          = frame_done_q;
    assign frame_cnt           = frame_cnt_q;
    assign err_sof             = err_sof_q;
    assign err_eol             = err_eol_q;
    assign err_data            = err_data_q;
    assign last_line_len       = last_len_q;

endmodule

// File: tb/tb_axis_video_checker.sv
// Scoreboard bench for axis_video_checker on a reduced 16x6 frame geometry.
module tb_axis_video_checker;

    localparam int H            = 16;
    localparam int V            = 6;
    localparam int BEAT_TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        clr_err;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_sof;
    logic        err_eol;
    logic        err_data;
    logic [11:0] last_line_len;

    always #5 clk = ~clk;

    axis_video_checker #(
        .H_PIX   (H),
        .V_LINES (V),
        .CHK_DATA(1'b1)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .enable             (enable),
        .clr_err            (clr_err),
        .s_axis_video_tdata (tdata),
        .s_axis_video_tvalid(tvalid),
        .s_axis_video_tready(tready),
        .s_axis_video_tuser (tuser),
        .s_axis_video_tlast (tlast),
        .frame_done         (frame_done),
        .frame_cnt          (frame_cnt),
        .err_sof            (err_sof),
        .err_eol            (err_eol),
        .err_data           (err_data),
        .last_line_len      (last_line_len)
    );

    typedef struct {
        int cnt;
        bit sof;
        bit eol;
        bit dat;
        int len;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total  = 0;
    int          bad    = 0;
    logic [17:0] pat    = 18'd0;
    bit          gapped = 1'b0;
    int          beat_n = 0;
    bit          bp_done = 1'b0;
    logic        en_prev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input int cnt, input bit sof, input bit eol, input bit dat, input int len);
        exp_t e;
        e.cnt = cnt;
        e.sof = sof;
        e.eol = eol;
        e.dat = dat;
        e.len = len;
        return e;
    endfunction

    function automatic logic [23:0] pack(input logic [17:0] p);
        return {p[17:12], 2'b00, p[11:6], 2'b00, p[5:0], 2'b00};
    endfunction

    // Monitor: every frame_done pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1 && frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_done: got pulse, want none (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("fd_frame_cnt", 32'(frame_cnt), mon_e.cnt);
                check("fd_err_sof", 32'(err_sof), 32'(mon_e.sof));
                check("fd_err_eol", 32'(err_eol), 32'(mon_e.eol));
                check("fd_err_data", 32'(err_data), 32'(mon_e.dat));
                check("fd_last_line_len", 32'(last_line_len), mon_e.len);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500us");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_beat(input logic [23:0] d, input logic u, input logic l);
        int waited;
        waited = 0;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        while (tready !== 1'b1 && waited < BEAT_TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (tready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: tready=%b, want 1", tready);
        end else begin
            @(negedge clk);
        end
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic pix(input logic u, input logic l, input bit glitch, input bit pad, input bit clr);
        logic [23:0] d;
        if (glitch) pat = pat + 18'd5;
        d = pack(pat);
        if (pad) d[0] = 1'b1;
        if (clr) clr_err = 1'b1;
        send_beat(d, u, l);
        clr_err = 1'b0;
        pat = pat + 18'd1;
        if (gapped) begin
            beat_n++;
            if (beat_n % 4 == 0) repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_line(input int len, input bit sof, input int glitch_px = -1,
                             input int pad_px = -1, input int clr_px = -1);
        for (int i = 0; i < len; i++) begin
            pix(sof && (i == 0), i == len - 1, i == glitch_px, i == pad_px, i == clr_px);
        end
    endtask

    task automatic send_frame(input exp_t e);
        for (int l = 0; l < V; l++) begin
            if (l == V - 1) sb.push_back(e);
            send_line(H, l == 0);
        end
    endtask

    task automatic clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        enable  = 1'b0;
        clr_err = 1'b0;
        tdata   = 24'd0;
        tvalid  = 1'b0;
        tuser   = 1'b0;
        tlast   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state and enable-to-tready latency
        check("rst_tready", 32'(tready), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_err_sof", 32'(err_sof), 0);
        check("rst_err_eol", 32'(err_eol), 0);
        check("rst_err_data", 32'(err_data), 0);
        check("rst_last_line_len", 32'(last_line_len), 0);
        rstn   = 1'b1;
        enable = 1'b1;
        check("tready_lag", 32'(tready), 0);
        @(negedge clk);
        check("tready_follow", 32'(tready), 1);

        // Nominal: junk before first SOF, then 3 gapped frames
        send_line(3, 1'b0);
        gapped = 1'b1;
        for (int f = 1; f <= 3; f++) send_frame(mk(f, 0, 0, 0, H));
        gapped = 1'b0;
        check("nom_frame_cnt", 32'(frame_cnt), 3);
        check("nom_errs", 32'({err_sof, err_eol, err_data}), 0);
        check("nom_last_line_len", 32'(last_line_len), H);

        // Early tlast on line 2, late tlast on line 4
        clr();
        check("clr_frame_cnt", 32'(frame_cnt), 0);
        check("clr_last_line_len", 32'(last_line_len), 0);
        for (int l = 0; l < V; l++) begin
            if (l == V - 1) sb.push_back(mk(1, 0, 1, 0, H));
            send_line((l == 2) ? 11 : (l == 4) ? 18 : H, l == 0);
            if (l == 2) begin
                check("early_err_eol", 32'(err_eol), 1);
                check("early_last_line_len", 32'(last_line_len), 11);
                clr();
                check("early_clr_err_eol", 32'(err_eol), 0);
            end
            if (l == 4) begin
                check("late_err_eol", 32'(err_eol), 1);
                check("late_last_line_len", 32'(last_line_len), 18);
            end
        end
        check("early_frame_cnt", 32'(frame_cnt), 1);

        // Payload glitch (+5) then resync; then a padding-bit error
        clr();
        for (int l = 0; l < V; l++) begin
            if (l == V - 1) sb.push_back(mk(1, 0, 0, 0, H));
            send_line(H, l == 0, (l == 1) ? 5 : -1);
            if (l == 1) begin
                check("glitch_err_data", 32'(err_data), 1);
                clr();
            end
        end
        check("glitch_resync_err_data", 32'(err_data), 0);
        for (int l = 0; l < V; l++) begin
            if (l == V - 1) sb.push_back(mk(2, 0, 0, 1, H));
            send_line(H, l == 0, -1, (l == 2) ? 3 : -1);
            if (l == 2) check("pad_err_data", 32'(err_data), 1);
        end

        // Mid-frame tuser on line 3 restarts the frame
        clr();
        for (int l = 0; l < 3; l++) send_line(H, l == 0);
        for (int l = 0; l < V; l++) begin
            if (l == V - 1) sb.push_back(mk(1, 1, 0, 0, H));
            send_line(H, l == 0);
            if (l == 0) check("midsof_err_sof", 32'(err_sof), 1);
        end
        check("midsof_frame_cnt", 32'(frame_cnt), 1);

        // Backpressure: enable toggles every 10 cycles while the source keeps tvalid up
        clr();
        bp_done = 1'b0;
        fork
            begin
                send_frame(mk(1, 0, 0, 0, H));
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    repeat (9) @(negedge clk);
                    if (!bp_done) begin
                        en_prev = enable;
                        enable  = ~enable;
                        check("bp_tready_lag", 32'(tready), 32'(en_prev));
                        @(negedge clk);
                        check("bp_tready_follow", 32'(tready), 32'(enable));
                    end
                end
                enable = 1'b1;
            end
        join
        @(negedge clk);
        check("bp_errs", 32'({err_sof, err_eol, err_data}), 0);
        check("bp_frame_cnt", 32'(frame_cnt), 1);

        // clr_err in the same cycle as a bad tlast: the set wins
        send_line(H, 1'b1);
        send_line(8, 1'b0, -1, -1, 7);
        check("clrset_err_eol", 32'(err_eol), 1);
        check("clrset_frame_cnt", 32'(frame_cnt), 0);
        check("clrset_last_line_len", 32'(last_line_len), 8);

        // Mid-frame reset, then a clean frame after leftover beats are discarded
        for (int i = 0; i < 5; i++) pix(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check("mrst_outputs", 32'({tready, frame_done, err_sof, err_eol, err_data}), 0);
        check("mrst_frame_cnt", 32'(frame_cnt), 0);
        check("mrst_last_line_len", 32'(last_line_len), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send_line(4, 1'b0);
        send_frame(mk(1, 0, 0, 0, H));
        check("post_rst_errs", 32'({err_sof, err_eol, err_data}), 0);
        check("post_rst_frame_cnt", 32'(frame_cnt), 1);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
